// File: rtl/lidar_feat_pkg.sv
// Shared types for the LiDAR feature path: coordinate type, box record, FSM states.
// The range gate default limit is only consumed when BBOX_RANGE_GATE_EN is defined.
package lidar_feat_pkg;

   localparam int unsigned COORD_W_DEF = 32;
   localparam int unsigned CNT_W_DEF   = 16;

   // Signed Q16.16 coordinate
   typedef logic signed [COORD_W_DEF-1:0] coord_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      OUTPUT = 2'd2
   } bbox_state_e;

   typedef struct packed {
      coord_t                 min_x;
      coord_t                 min_y;
      coord_t                 min_z;
      coord_t                 max_x;
      coord_t                 max_y;
      coord_t                 max_z;
      logic [CNT_W_DEF-1:0]   count;
      logic                   error;
   } bbox_t;

   // 200.0 m in Q16.16
   localparam coord_t RANGE_LIMIT_DEF = 32'sh00C8_0000;

endpackage

// File: rtl/axis_minmax.sv
// Per-axis signed min/max register pair with init, update and clear controls.
module axis_minmax #(
   parameter int unsigned W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_init,
   input  logic                i_update,
   input  logic                i_clear,
   input  logic signed [W-1:0] i_p,
   output logic signed [W-1:0] o_min,
   output logic signed [W-1:0] o_max
);

   logic signed [W-1:0] r_min;
   logic signed [W-1:0] r_max;
   logic                w_lt;
   logic                w_gt;

   assign w_lt = (i_p < r_min);
   assign w_gt = (i_p > r_max);

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_min <= '0;
         r_max <= '0;
      end else if (i_init) begin
         r_min <= i_p;
         r_max <= i_p;
      end else if (i_update) begin
         if (w_lt) r_min <= i_p;
         if (w_gt) r_max <= i_p;
      end
   end

   assign o_min = r_min;
   assign o_max = r_max;

endmodule

// File: rtl/bounding_box_accumulator.sv
// Accumulates a framed stream of LiDAR points into one axis-aligned box per cluster.
// Optional macro BBOX_RANGE_GATE_EN excludes out-of-range points from the box.
module bounding_box_accumulator
   import lidar_feat_pkg::*;
#(
   parameter int unsigned COORD_W    = COORD_W_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned MIN_POINTS = 1
`ifdef BBOX_RANGE_GATE_EN
   ,
   parameter logic signed [COORD_W-1:0] RANGE_LIMIT = COORD_W'(RANGE_LIMIT_DEF)
`endif
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      pt_valid,
   output logic                      pt_ready,
   input  logic signed [COORD_W-1:0] pt_x,
   input  logic signed [COORD_W-1:0] pt_y,
   input  logic signed [COORD_W-1:0] pt_z,
   input  logic                      pt_first,
   input  logic                      pt_last,
   output logic                      box_valid,
   input  logic                      box_ready,
   output logic signed [COORD_W-1:0] min_x,
   output logic signed [COORD_W-1:0] min_y,
   output logic signed [COORD_W-1:0] min_z,
   output logic signed [COORD_W-1:0] max_x,
   output logic signed [COORD_W-1:0] max_y,
   output logic signed [COORD_W-1:0] max_z,
   output logic [CNT_W-1:0]          point_count,
   output logic                      box_error,
   output logic                      proto_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   bbox_state_e      r_state;
   bbox_state_e      w_state_nxt;
   logic             r_pt_ready;
   logic             r_box_valid;
   logic             r_box_error;
   logic             r_proto_err;
   logic             r_sat;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic             w_sat_nxt;
   logic             w_err_nxt;
   logic             w_accept;
   logic             w_start;
   logic             w_add;
   logic             w_proto;
   logic             w_gated;
   logic             w_have;
   logic             w_load;
   logic             w_upd;
   logic             w_clr;

   assign w_accept = pt_valid && r_pt_ready;

`ifdef BBOX_RANGE_GATE_EN
   localparam logic signed [COORD_W-1:0] COORD_MOST_NEG = {1'b1, {(COORD_W-1){1'b0}}};

   function automatic logic f_out_of_range(input logic signed [COORD_W-1:0] p);
      return (p == COORD_MOST_NEG) || (p > RANGE_LIMIT) || (p < -RANGE_LIMIT);
   endfunction

   // Tracks whether the open cluster has seen any in-range point yet
   logic r_have;

   assign w_gated = f_out_of_range(pt_x) || f_out_of_range(pt_y) || f_out_of_range(pt_z);
   assign w_have  = r_have;

   always_ff @(posedge clk) begin
      if (rst)          r_have <= 1'b0;
      else if (w_start) r_have <= !w_gated;
      else if (w_load)  r_have <= 1'b1;
   end
`else
   assign w_gated = 1'b0;
   assign w_have  = 1'b1;
`endif

   // The first contributing point loads the box; later ones widen it
   assign w_load = (w_start || (w_add && !w_have)) && !w_gated;
   assign w_upd  = w_add && w_have && !w_gated;
   assign w_clr  = w_start && w_gated;

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_add       = 1'b0;
      w_proto     = 1'b0;
      w_count_nxt = r_count;
      w_sat_nxt   = r_sat;
      w_err_nxt   = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (pt_first) begin
                  w_start     = 1'b1;
                  w_state_nxt = pt_last ? OUTPUT : ACCUM;
               end else begin
                  w_proto = 1'b1;
               end
            end
         end
         ACCUM: begin
            if (w_accept) begin
               if (pt_first) begin
                  w_start     = 1'b1;
                  w_proto     = 1'b1;
                  w_state_nxt = pt_last ? OUTPUT : ACCUM;
               end else begin
                  w_add = 1'b1;
                  if (pt_last) w_state_nxt = OUTPUT;
               end
            end
         end
         OUTPUT: begin
            if (r_box_valid && box_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase

      if (w_load) begin
         w_count_nxt = CNT_W'(1);
         w_sat_nxt   = 1'b0;
      end else if (w_clr) begin
         w_count_nxt = '0;
         w_sat_nxt   = 1'b0;
      end else if (w_upd) begin
         if (r_count == CNT_MAX) w_sat_nxt = 1'b1;
         else                    w_count_nxt = r_count + CNT_W'(1);
      end

      w_err_nxt = (32'(w_count_nxt) < MIN_POINTS) || w_sat_nxt || (w_count_nxt == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_pt_ready  <= 1'b1;
         r_box_valid <= 1'b0;
         r_box_error <= 1'b0;
         r_proto_err <= 1'b0;
         r_count     <= '0;
         r_sat       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pt_ready  <= (w_state_nxt != OUTPUT);
         r_box_valid <= (w_state_nxt == OUTPUT);
         r_proto_err <= w_proto;
         r_count     <= w_count_nxt;
         r_sat       <= w_sat_nxt;
         // Error flag is captured only as the box is presented, then held
         if ((w_state_nxt == OUTPUT) && (r_state != OUTPUT)) r_box_error <= w_err_nxt;
      end
   end

   axis_minmax #(.W(COORD_W)) u_axis_x (
      .clk(clk), .rst(rst), .i_init(w_load), .i_update(w_upd), .i_clear(w_clr),
      .i_p(pt_x), .o_min(min_x), .o_max(max_x)
   );

   axis_minmax #(.W(COORD_W)) u_axis_y (
      .clk(clk), .rst(rst), .i_init(w_load), .i_update(w_upd), .i_clear(w_clr),
      .i_p(pt_y), .o_min(min_y), .o_max(max_y)
   );

   axis_minmax #(.W(COORD_W)) u_axis_z (
      .clk(clk), .rst(rst), .i_init(w_load), .i_update(w_upd), .i_clear(w_clr),
      .i_p(pt_z), .o_min(min_z), .o_max(max_z)
   );

   assign pt_ready    = r_pt_ready;
   assign box_valid   = r_box_valid;
   assign point_count = r_count;
   assign box_error   = r_box_error;
   assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_bounding_box_accumulator.sv
// Bench for bounding_box_accumulator: a default instance and a MIN_POINTS=3/CNT_W=2 instance share stimulus.
// Gate scenarios run only when BBOX_RANGE_GATE_EN is defined.
module tb_bounding_box_accumulator;

`ifdef BBOX_RANGE_GATE_EN
   localparam bit GATE_ON = 1'b1;
`else
   localparam bit GATE_ON = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
   } pt_t;

   logic        clk;
   logic        rst;
   logic        pt_valid;
   logic [31:0] pt_x, pt_y, pt_z;
   logic        pt_first, pt_last;
   logic        box_ready;

   logic              rdy0, bv0, err0, pe0;
   logic [2:0][31:0]  mn0, mx0;
   logic [15:0]       cnt0;
   logic              rdy1, bv1, err1, pe1;
   logic [2:0][31:0]  mn1, mx1;
   logic [1:0]        cnt1;

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   // Model state
   pt_t         pq[$];
   bit          m_out, m_busy, m_proto;
   logic [31:0] e_mn[3], e_mx[3];
   int          e_cnt[2];
   bit          e_err[2];

   bounding_box_accumulator u_dut0 (
      .clk(clk), .rst(rst), .pt_valid(pt_valid), .pt_ready(rdy0),
      .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z), .pt_first(pt_first), .pt_last(pt_last),
      .box_valid(bv0), .box_ready(box_ready),
      .min_x(mn0[0]), .min_y(mn0[1]), .min_z(mn0[2]),
      .max_x(mx0[0]), .max_y(mx0[1]), .max_z(mx0[2]),
      .point_count(cnt0), .box_error(err0), .proto_err(pe0)
   );

   bounding_box_accumulator #(.CNT_W(2), .MIN_POINTS(3)) u_dut1 (
      .clk(clk), .rst(rst), .pt_valid(pt_valid), .pt_ready(rdy1),
      .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z), .pt_first(pt_first), .pt_last(pt_last),
      .box_valid(bv1), .box_ready(box_ready),
      .min_x(mn1[0]), .min_y(mn1[1]), .min_z(mn1[2]),
      .max_x(mx1[0]), .max_y(mx1[1]), .max_z(mx1[2]),
      .point_count(cnt1), .box_error(err1), .proto_err(pe1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] q(input int v);
      return 32'(v <<< 16);
   endfunction

   function automatic bit gated(input logic [31:0] v);
      longint a;
      a = longint'($signed(v));
      if (a < 0) a = -a;
      return GATE_ON && (a > 64'sd13107200);
   endfunction

   // Box expectation from the cluster's point list, for both parameter sets
   task automatic finalize();
      int n = 0;
      logic signed [31:0] mn[3], mx[3], c[3];
      for (int k = 0; k < 3; k++) begin mn[k] = '0; mx[k] = '0; end
      for (int i = 0; i < pq.size(); i++) begin
         c[0] = pq[i].x; c[1] = pq[i].y; c[2] = pq[i].z;
         if (!(gated(c[0]) || gated(c[1]) || gated(c[2]))) begin
            for (int k = 0; k < 3; k++) begin
               if (n == 0) begin mn[k] = c[k]; mx[k] = c[k]; end
               else begin
                  if (c[k] < mn[k]) mn[k] = c[k];
                  if (c[k] > mx[k]) mx[k] = c[k];
               end
            end
            n++;
         end
      end
      for (int k = 0; k < 3; k++) begin e_mn[k] = mn[k]; e_mx[k] = mx[k]; end
      e_cnt[0] = (n > 65535) ? 65535 : n;
      e_err[0] = (n < 1) || (n > 65535);
      e_cnt[1] = (n > 3) ? 3 : n;
      e_err[1] = (n < 3) || (n > 3);
      m_out  = 1'b1;
      m_busy = 1'b0;
   endtask

   // Protocol model, evaluated on each clock edge from the inputs seen there
   initial begin
      m_out = 0; m_busy = 0; m_proto = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_out = 0; m_busy = 0; m_proto = 0;
            pq.delete();
         end else begin
            m_proto = 0;
            if (m_out) begin
               if (box_ready) m_out = 0;
            end else if (pt_valid) begin
               if (pt_first) begin
                  if (m_busy) m_proto = 1;
                  pq.delete();
                  pq.push_back('{pt_x, pt_y, pt_z});
                  m_busy = 1;
                  if (pt_last) finalize();
               end else if (!m_busy) begin
                  m_proto = 1;
               end else begin
                  pq.push_back('{pt_x, pt_y, pt_z});
                  if (pt_last) finalize();
               end
            end
         end
      end
   end

   // Compare every cycle, away from the active edge
   initial begin
      wait (started);
      forever begin
         @(negedge clk);
         chk("pt_ready0", 64'(rdy0), 64'(!m_out));
         chk("pt_ready1", 64'(rdy1), 64'(!m_out));
         chk("box_valid0", 64'(bv0), 64'(m_out));
         chk("box_valid1", 64'(bv1), 64'(m_out));
         chk("proto_err0", 64'(pe0), 64'(m_proto));
         chk("proto_err1", 64'(pe1), 64'(m_proto));
         if (m_out) begin
            for (int k = 0; k < 3; k++) begin
               chk("min0", 64'(mn0[k]), 64'(e_mn[k]));
               chk("max0", 64'(mx0[k]), 64'(e_mx[k]));
               chk("min1", 64'(mn1[k]), 64'(e_mn[k]));
               chk("max1", 64'(mx1[k]), 64'(e_mx[k]));
            end
            chk("count0", 64'(cnt0), 64'(e_cnt[0]));
            chk("count1", 64'(cnt1), 64'(e_cnt[1]));
            chk("error0", 64'(err0), 64'(e_err[0]));
            chk("error1", 64'(err1), 64'(e_err[1]));
         end
      end
   end

   task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                       input logic f, input logic l);
      int t = 0;
      while (!rdy0 && t < 50) begin @(posedge clk); #1; t++; end
      if (t >= 50) chk("pt_ready_timeout", 64'(rdy0), 64'd1);
      pt_valid = 1'b1; pt_x = x; pt_y = y; pt_z = z; pt_first = f; pt_last = l;
      @(posedge clk); #1;
      pt_valid = 1'b0; pt_first = 1'b0; pt_last = 1'b0;
   endtask

   task automatic take_box();
      int t = 0;
      while (!bv0 && t < 50) begin @(posedge clk); #1; t++; end
      if (t >= 50) chk("box_valid_timeout", 64'(bv0), 64'd1);
      box_ready = 1'b1;
      @(posedge clk); #1;
      box_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; pt_valid = 1'b0; pt_x = '0; pt_y = '0; pt_z = '0;
      pt_first = 1'b0; pt_last = 1'b0; box_ready = 1'b0;
      @(posedge clk); #1;
      started = 1'b1;
      @(posedge clk); #1;
      chk("rst_pt_ready", 64'(rdy0), 64'd1);
      chk("rst_box_valid", 64'(bv0), 64'd0);
      chk("rst_min_x", 64'(mn0[0]), 64'd0);
      chk("rst_max_z", 64'(mx0[2]), 64'd0);
      chk("rst_count", 64'(cnt0), 64'd0);
      chk("rst_error", 64'(err0), 64'd0);
      chk("rst_proto", 64'(pe0), 64'd0);
      rst = 1'b0;

      // Three-point cluster; box must be valid the cycle after the last point
      send(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 1, 0);
      send(32'hFFFC_0000, 32'h0005_0000, 32'h0000_8000, 0, 0);
      send(32'h0002_8000, 32'hFFFF_0000, 32'h0007_0000, 0, 1);
      chk("c1_valid", 64'(bv0), 64'd1);
      chk("c1_min_x", 64'(mn0[0]), 64'h0000_0000_FFFC_0000);
      chk("c1_min_y", 64'(mn0[1]), 64'h0000_0000_FFFF_0000);
      chk("c1_min_z", 64'(mn0[2]), 64'h0000_0000_0000_8000);
      chk("c1_max_x", 64'(mx0[0]), 64'h0000_0000_0002_8000);
      chk("c1_max_y", 64'(mx0[1]), 64'h0000_0000_0005_0000);
      chk("c1_max_z", 64'(mx0[2]), 64'h0000_0000_0007_0000);
      chk("c1_count", 64'(cnt0), 64'd3);
      chk("c1_error", 64'(err0), 64'd0);
      chk("c1_count1", 64'(cnt1), 64'd3);
      chk("c1_error1", 64'(err1), 64'd0);
      take_box();

      // One-point cluster at the extremes, held without box_ready
      send(32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1, 1);
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 64'(bv0), 64'd1);
         chk("hold_ready", 64'(rdy0), 64'd0);
`ifndef BBOX_RANGE_GATE_EN
         chk("hold_min_x", 64'(mn0[0]), 64'h0000_0000_7FFF_FFFF);
         chk("hold_max_y", 64'(mx0[1]), 64'h0000_0000_8000_0000);
         chk("hold_count", 64'(cnt0), 64'd1);
         chk("hold_error1", 64'(err1), 64'd1);
`endif
         @(posedge clk); #1;
      end
      take_box();
      chk("post_hs_ready", 64'(rdy0), 64'd1);

      // Framing errors: stray point in IDLE, then restart mid-cluster
      send(q(1), q(1), q(1), 0, 0);
      chk("stray_proto", 64'(pe0), 64'd1);
      send(q(1), q(1), q(1), 1, 0);
      send(q(2), q(2), q(2), 0, 0);
      send(q(5), q(5), q(5), 1, 0);
      chk("restart_proto", 64'(pe0), 64'd1);
      send(q(6), q(4), q(6), 0, 1);
      chk("restart_count", 64'(cnt0), 64'd2);
      chk("restart_min_x", 64'(mn0[0]), 64'h0000_0000_0005_0000);
      chk("restart_min_y", 64'(mn0[1]), 64'h0000_0000_0004_0000);
      take_box();

      // Reset mid-cluster discards partial state
      send(q(9), q(9), q(9), 1, 0);
      send(q(10), q(10), q(10), 0, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      send(q(-3), q(-3), q(-3), 1, 1);
      chk("rst_new_count", 64'(cnt0), 64'd1);
      chk("rst_new_min_x", 64'(mn0[0]), 64'h0000_0000_FFFD_0000);
      take_box();

      // Two points: below MIN_POINTS=3 on the second instance
      send(q(1), 0, 0, 1, 0);
      send(q(2), 0, 0, 0, 1);
      chk("two_count1", 64'(cnt1), 64'd2);
      chk("two_error1", 64'(err1), 64'd1);
      chk("two_error0", 64'(err0), 64'd0);
      // New point offered during the box handshake must wait a cycle
      pt_valid = 1'b1; pt_first = 1'b1; pt_last = 1'b1;
      pt_x = q(7); pt_y = q(7); pt_z = q(7); box_ready = 1'b1;
      @(posedge clk); #1;
      box_ready = 1'b0;
      chk("hs_no_accept", 64'(bv0), 64'd0);
      @(posedge clk); #1;
      pt_valid = 1'b0; pt_first = 1'b0; pt_last = 1'b0;
      chk("late_accept", 64'(bv0), 64'd1);
      chk("late_min_x", 64'(mn0[0]), 64'h0000_0000_0007_0000);
      take_box();

      // Five points saturate the 2-bit counter
      send(q(1), q(-1), 0, 1, 0);
      send(q(2), q(-2), 0, 0, 0);
      send(q(3), q(-3), 0, 0, 0);
      send(q(4), q(-4), 0, 0, 0);
      send(q(5), q(-5), 0, 0, 1);
      chk("sat_count0", 64'(cnt0), 64'd5);
      chk("sat_count1", 64'(cnt1), 64'd3);
      chk("sat_error1", 64'(err1), 64'd1);
      chk("sat_min_y", 64'(mn0[1]), 64'h0000_0000_FFFB_0000);
      take_box();

`ifdef BBOX_RANGE_GATE_EN
      // Out-of-range point is skipped; next point initialises the box
      send(32'h012C_0000, 0, 0, 1, 0);
      send(q(1), q(1), q(1), 0, 1);
      chk("gate_count", 64'(cnt0), 64'd1);
      chk("gate_min_x", 64'(mn0[0]), 64'h0000_0000_0001_0000);
      chk("gate_max_x", 64'(mx0[0]), 64'h0000_0000_0001_0000);
      take_box();
      send(32'h8000_0000, 0, 0, 1, 0);
      send(0, 32'h7FFF_FFFF, 0, 0, 1);
      chk("allgated_count", 64'(cnt0), 64'd0);
      chk("allgated_error", 64'(err0), 64'd1);
      chk("allgated_min_x", 64'(mn0[0]), 64'd0);
      take_box();
`endif

      repeat (3) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
